pkt_rr_arbiter: RTL

//  Packet-atomic round-robin arbiter that shares one stream FIFO write port among N requesters.

---
 rtl/pkt_arb_pkg.sv | 12 +
 rtl/pkt_rr_arbiter_rr_pick.sv | 37 +++
 rtl/pkt_rr_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and constants for the packet round-robin arbiter slice.
package pkt_arb_pkg;

  localparam int KEEP_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

endpackage : pkt_arb_pkg

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick. Rotates the request vector so the
// lane after last_gnt sits at bit 0, priority-encodes the lowest set bit and
// maps the offset back to an absolute index. Shared with other lane arbiters.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic          any,
  output logic [IW-1:0] gnt
);

  logic [IW:0]  shamt;
  logic [N-1:0] rot;
  logic [IW:0]  off;
  logic [IW:0]  sum;

  // Rotate, find the first requester after last_gnt, and wrap the index.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    any   = |req;
    shamt = {1'b0, last_gnt} + 1'b1;
    rot   = N'({req, req} >> shamt);
    off   = '0;
    // Scan downwards so the lowest set bit wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = (IW+1)'(i);
    end
    sum = shamt + off;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    gnt = sum[IW-1:0];
  end

endmodule : rr_pick

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-atomic round-robin arbiter feeding one stream FIFO
// write port. A grant is held from the first beat to the beat carrying last.
// Optional stall watchdog: define PKT_ARB_WATCHDOG_EN to enable the counter
// and the ABORT state that closes a stalled packet with an empty last beat.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 256,
  parameter int WD_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          s_valid,
  input  logic [N_REQ*WIDTH-1:0]    s_data,
  input  logic [N_REQ*KEEP_W-1:0]   s_keep,
  input  logic [N_REQ-1:0]          s_last,
  output logic [N_REQ-1:0]          s_ready,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_wr_data,
  output logic [KEEP_W-1:0]         fifo_wr_keep,
  output logic                      fifo_wr_last,
  input  logic                      fifo_full,
  output logic [$clog2(N_REQ)-1:0]  gnt_idx,
  output logic                      busy,
  output logic                      wd_abort
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || WD_CYCLES < 1) begin : g_cfg_check
    $error("pkt_rr_arbiter: N_REQ must be 2..8 and WD_CYCLES at least 1");
  end

  arb_state_t    state, state_nxt;
  logic [IW-1:0] gnt, last_gnt, pick_idx;
  logic          pick_any;
  logic          beat_ok;

`ifdef PKT_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .req      (s_valid),
    .last_gnt (last_gnt),
    .any      (pick_any),
    .gnt      (pick_idx)
  );

  // Next-state logic, per-lane ready, and the FIFO write mux (zero unless writing).
  always_comb begin
    state_nxt    = state;
    s_ready      = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    fifo_wr_keep = '0;
    fifo_wr_last = 1'b0;
    wd_abort     = 1'b0;
    beat_ok      = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (pick_any) state_nxt = PKT;
        end
        PKT: begin
          s_ready[gnt] = !fifo_full;
          beat_ok      = s_valid[gnt] && !fifo_full;
          fifo_wr_en   = beat_ok;
          if (beat_ok) begin
            fifo_wr_data = s_data[gnt*WIDTH +: WIDTH];
            fifo_wr_keep = s_keep[gnt*KEEP_W +: KEEP_W];
            fifo_wr_last = s_last[gnt];
            if (s_last[gnt]) state_nxt = IDLE;
          end
`ifdef PKT_ARB_WATCHDOG_EN
          // Source stall (FIFO has room, lane silent) that hits the limit.
          else if (!fifo_full && wd_cnt == WD_W'(WD_CYCLES - 1)) begin
            state_nxt = ABORT;
          end
`endif
        end
`ifdef PKT_ARB_WATCHDOG_EN
        ABORT: begin
          // Close the stalled packet with an empty last beat.
          if (!fifo_full) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_last = 1'b1;
            wd_abort     = 1'b1;
            state_nxt    = IDLE;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      last_gnt <= IW'(N_REQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_any) gnt <= pick_idx;
      if ((beat_ok && s_last[gnt]) || wd_abort) last_gnt <= gnt;
    end
  end

`ifdef PKT_ARB_WATCHDOG_EN
  // Stall counter: counts silent-source cycles in PKT, clears on any accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n || state != PKT || beat_ok) begin
      wd_cnt <= '0;
    end else if (!fifo_full) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`endif

  assign gnt_idx = rst_n ? gnt : '0;
  assign busy    = rst_n && (state != IDLE);

endmodule : pkt_rr_arbiter
